// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and memory-port signals of the instruction memory arbiter.
// Ports (signals): fetch_req_i/fetch_addr_i/fetch_ready_o/fetch_valid_o/fetch_instr_o/fetch_err_o (CPU fetch),
// load_req_i/load_addr_i/load_data_i/load_ack_o (loader), mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i (memory).
// Modport slave is the arbiter side; modport master is the requesters plus memory side.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              fetch_req_i;
    logic [31:0]       fetch_addr_i;
    logic              fetch_ready_o;
    logic              fetch_valid_o;
    logic [31:0]       fetch_instr_o;
    logic              fetch_err_o;
    logic              load_req_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic [7:0]        load_data_i;
    logic              load_ack_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [7:0]        mem_wdata_o;
    logic [7:0]        mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i, mem_rdata_i,
        output fetch_ready_o, fetch_valid_o, fetch_instr_o, fetch_err_o, load_ack_o,
        output mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i, mem_rdata_i,
        input  fetch_ready_o, fetch_valid_o, fetch_instr_o, fetch_err_o, load_ack_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the byte-wide instruction memory port between CPU word fetches and loader byte writes.
// Ports: clk_i (clock), rst_ni (async active-low reset), bus (imem_port_arbiter_if.slave: fetch request/response,
// loader write/ack, registered memory address/write-enable/write-data and one-cycle-latency read data).
module imem_port_arbiter #(
    parameter int DEPTH_BYTES = 2048,
    parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    imem_port_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;
    localparam logic FETCH = 1'b0;
    localparam logic LOAD  = 1'b1;

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic              last_grant;
    logic [23:0]       shift;
    logic [31:0]       instr;
    logic              err, valid, ack, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              legal, fetch_ready, grant_fetch, grant_load;

    always_comb begin
        legal       = bus.fetch_addr_i[1:0] == 2'b00 && bus.fetch_addr_i <= 32'(DEPTH_BYTES - 4);
        fetch_ready = state == IDLE && (!bus.load_req_i || last_grant == LOAD);
        grant_fetch = fetch_ready && bus.fetch_req_i;
        grant_load  = state == IDLE && bus.load_req_i && !grant_fetch;
        state_nxt   = state;
        case (state)
            IDLE:    state_nxt = grant_load ? WRITE : grant_fetch ? (legal ? READ : RESP) : IDLE;
            WRITE:   state_nxt = IDLE;
            READ:    state_nxt = cnt == 2'd3 ? DRAIN : READ;
            DRAIN:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data trails the address by one cycle, so byte k is captured while cnt is k+1
    // (byte 3 in DRAIN); the shift register keeps the response output stable until RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last_grant <= LOAD;
            shift      <= '0;
            instr      <= '0;
            err        <= 1'b0;
            valid      <= 1'b0;
            ack        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state  <= state_nxt;
            valid  <= state_nxt == RESP;
            ack    <= state_nxt == WRITE;
            mem_we <= state_nxt == WRITE;
            if (grant_load) begin
                mem_addr   <= bus.load_addr_i;
                mem_wdata  <= bus.load_data_i;
                last_grant <= LOAD;
            end
            if (grant_fetch) begin
                last_grant <= FETCH;
                cnt        <= 2'd0;
                if (legal) mem_addr <= bus.fetch_addr_i[ADDR_W-1:0];
                else begin
                    instr <= '0;
                    err   <= 1'b1;
                end
            end
            if (state == READ) begin
                cnt <= cnt + 2'd1;
                if (cnt != 2'd3) mem_addr <= mem_addr + ADDR_W'(1);
                if (cnt != 2'd0) shift <= {shift[15:0], bus.mem_rdata_i};
            end
            if (state == DRAIN) begin
                instr <= {shift, bus.mem_rdata_i};
                err   <= 1'b0;
            end
        end
    end

    assign bus.fetch_ready_o = fetch_ready;
    assign bus.fetch_valid_o = valid;
    assign bus.fetch_instr_o = instr;
    assign bus.fetch_err_o   = err;
    assign bus.load_ack_o    = ack;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_we_o      = mem_we;
    assign bus.mem_wdata_o   = mem_wdata;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: self-checking bench for imem_port_arbiter with a byte memory model and a reference model.
// Ports: none (top-level bench).
module tb_imem_port_arbiter;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          lat;
    } fvec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } lvec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(AW)) bus ();
    imem_port_arbiter #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    logic [7:0] mem [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    int checks = 0;
    int passes = 0;

    // Synchronous byte memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
        bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end

    logic [31:0]   f_instr;
    logic          f_err, f_vafter;
    int            f_lat;
    logic [AW-1:0] f_addr [4];
    logic [AW-1:0] f_abefore;
    int            l_lat;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [7:0]    l_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit model_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 32'(DEPTH - 4));
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] a);
        int i;
        i = int'(a);
        return model_legal(a) ? {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]} : 32'h0;
    endfunction

    task automatic fetch_txn(input logic [31:0] a, input bit scramble);
        int w;
        f_instr = 'x;
        f_err = 'x;
        f_lat = 0;
        f_vafter = 'x;
        @(negedge clk);
        bus.fetch_req_i = 1'b1;
        bus.fetch_addr_i = a;
        #1;
        w = 0;
        while (!bus.fetch_ready_o && w < 30) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("fetch_ready", bus.fetch_ready_o, 1);
        f_abefore = bus.mem_addr_o;
        @(posedge clk);
        #1;
        bus.fetch_req_i = 1'b0;
        if (scramble) bus.fetch_addr_i = $urandom;
        for (int k = 1; k <= 20 && f_lat == 0; k++) begin
            @(negedge clk);
            if (k <= 4) f_addr[k-1] = bus.mem_addr_o;
            if (bus.fetch_valid_o) begin
                f_lat = k;
                f_instr = bus.fetch_instr_o;
                f_err = bus.fetch_err_o;
            end
        end
        @(negedge clk);
        f_vafter = bus.fetch_valid_o;
    endtask

    task automatic load_txn(input logic [AW-1:0] a, input logic [7:0] d);
        l_lat = 0;
        l_we = 'x;
        l_addr = 'x;
        l_data = 'x;
        @(negedge clk);
        bus.load_req_i = 1'b1;
        bus.load_addr_i = a;
        bus.load_data_i = d;
        for (int k = 1; k <= 20 && l_lat == 0; k++) begin
            @(negedge clk);
            if (bus.load_ack_o) begin
                l_lat = k;
                l_we = bus.mem_we_o;
                l_addr = bus.mem_addr_o;
                l_data = bus.mem_wdata_o;
            end
        end
        bus.load_req_i = 1'b0;
    endtask

    fvec_t ftab [7];
    lvec_t ltab [4];
    logic [24:0] fg, rd, ak, efg, eak;
    logic [31:0] ra;
    logic [AW-1:0] la;
    logic [7:0] ld;
    int t, vcount;
    bit fturn;

    initial begin
        ftab[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 6};
        ftab[1] = '{32'h0000_0002, 32'h0,         1'b1, 1};
        ftab[2] = '{32'h0000_07FD, 32'h0,         1'b1, 1};
        ftab[3] = '{32'h0000_0800, 32'h0,         1'b1, 1};
        ftab[4] = '{32'h0000_07FC, 32'h0123_4567, 1'b0, 6};
        ftab[5] = '{32'hFFFF_FFFC, 32'h0,         1'b1, 1};
        ftab[6] = '{32'h8000_0010, 32'h0,         1'b1, 1};
        ltab[0] = '{11'h20, 8'h11};
        ltab[1] = '{11'h21, 8'h22};
        ltab[2] = '{11'h22, 8'h33};
        ltab[3] = '{11'h23, 8'h44};
        bus.fetch_req_i = 1'b0;
        bus.fetch_addr_i = '0;
        bus.load_req_i = 1'b0;
        bus.load_addr_i = '0;
        bus.load_data_i = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        mem[16'h10] = 8'hDE; mem[16'h11] = 8'hAD; mem[16'h12] = 8'hBE; mem[16'h13] = 8'hEF;
        mem[16'h7FC] = 8'h01; mem[16'h7FD] = 8'h23; mem[16'h7FE] = 8'h45; mem[16'h7FF] = 8'h67;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.fetch_valid_o, 0);
        chk("rst_err", bus.fetch_err_o, 0);
        chk("rst_instr", bus.fetch_instr_o, 0);
        chk("rst_ack", bus.load_ack_o, 0);
        chk("rst_we", bus.mem_we_o, 0);
        chk("rst_addr", 32'(bus.mem_addr_o), 0);
        chk("rst_wdata", 32'(bus.mem_wdata_o), 0);
        chk("rst_ready", bus.fetch_ready_o, 1);
        rst_n = 1'b1;
        @(negedge clk);
        // Contention from reset: fetch needs 7 cycles of port time, a load 2; fetch wins first.
        bus.fetch_req_i = 1'b1;
        bus.fetch_addr_i = 32'h10;
        bus.load_req_i = 1'b1;
        bus.load_addr_i = 11'h60;
        bus.load_data_i = 8'h5A;
        for (int c = 0; c < 25; c++) begin
            #1;
            fg[c] = bus.fetch_req_i & bus.fetch_ready_o;
            rd[c] = bus.fetch_ready_o;
            ak[c] = bus.load_ack_o;
            @(negedge clk);
        end
        bus.fetch_req_i = 1'b0;
        bus.load_req_i = 1'b0;
        ref_mem[16'h60] = 8'h5A;
        efg = '0;
        eak = '0;
        t = 0;
        fturn = 1'b1;
        while (t < 25) begin
            if (fturn) begin
                efg[t] = 1'b1;
                t += 7;
            end else begin
                if (t + 1 < 25) eak[t+1] = 1'b1;
                t += 2;
            end
            fturn = !fturn;
        end
        chk("contend_fetch_grants", 32'(fg), 32'(efg));
        chk("contend_ready", 32'(rd), 32'(efg));
        chk("contend_load_acks", 32'(ak), 32'(eak));
        for (int i = 0; i < 7; i++) begin
            fetch_txn(ftab[i].addr, 1'b0);
            chk($sformatf("tab%0d_instr", i), f_instr, ftab[i].instr);
            chk($sformatf("tab%0d_err", i), f_err, ftab[i].err);
            chk($sformatf("tab%0d_lat", i), f_lat, ftab[i].lat);
            chk($sformatf("tab%0d_pulse", i), f_vafter, 0);
            if (ftab[i].err) chk($sformatf("tab%0d_no_access", i), 32'(f_addr[0]), 32'(f_abefore));
            else for (int k = 0; k < 4; k++)
                chk($sformatf("tab%0d_addr%0d", i, k), 32'(f_addr[k]), ftab[i].addr + 32'(k));
        end
        for (int i = 0; i < 4; i++) begin
            load_txn(ltab[i].addr, ltab[i].data);
            ref_mem[ltab[i].addr] = ltab[i].data;
            chk($sformatf("load%0d_lat", i), l_lat, 1);
            chk($sformatf("load%0d_we", i), l_we, 1);
            chk($sformatf("load%0d_addr", i), 32'(l_addr), 32'(ltab[i].addr));
            chk($sformatf("load%0d_data", i), 32'(l_data), 32'(ltab[i].data));
        end
        fetch_txn(32'h20, 1'b0);
        chk("loaded_fetch_instr", f_instr, 32'h1122_3344);
        chk("loaded_fetch_lat", f_lat, 6);
        fetch_txn(32'h10, 1'b1);
        chk("withdraw_instr", f_instr, 32'hDEAD_BEEF);
        chk("withdraw_lat", f_lat, 6);
        @(negedge clk);
        bus.fetch_req_i = 1'b1;
        bus.fetch_addr_i = 32'h10;
        #1;
        chk("midrst_ready", bus.fetch_ready_o, 1);
        @(posedge clk);
        #1;
        bus.fetch_req_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_addr_before", 32'(bus.mem_addr_o), 32'h12);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.fetch_valid_o, 0);
        chk("midrst_instr", bus.fetch_instr_o, 0);
        chk("midrst_err", bus.fetch_err_o, 0);
        chk("midrst_addr", 32'(bus.mem_addr_o), 0);
        chk("midrst_we", bus.mem_we_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            vcount += int'(bus.fetch_valid_o) + int'(bus.load_ack_o);
        end
        chk("midrst_no_response", vcount, 0);
        fetch_txn(32'h10, 1'b0);
        chk("postrst_instr", f_instr, 32'hDEAD_BEEF);
        chk("postrst_lat", f_lat, 6);
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    la = 11'(32'h40 + $urandom_range(0, 63));
                    ld = 8'($urandom);
                    load_txn(la, ld);
                    ref_mem[la] = ld;
                    chk("rnd_load_lat", l_lat, 1);
                    chk("rnd_load_addr", 32'(l_addr), 32'(la));
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: ra = 32'h40 + 4 * $urandom_range(0, 15);
                        1: ra = $urandom;
                        2: ra = 32'(DEPTH - 8) + $urandom_range(0, 8);
                        default: ra = 32'h40 + $urandom_range(0, 63);
                    endcase
                    fetch_txn(ra, $urandom_range(0, 1) == 1);
                    chk($sformatf("rnd_fetch_instr@%h", ra), f_instr, model_instr(ra));
                    chk($sformatf("rnd_fetch_err@%h", ra), f_err, model_legal(ra) ? 0 : 1);
                    chk($sformatf("rnd_fetch_lat@%h", ra), f_lat, model_legal(ra) ? 6 : 1);
                end
            endcase
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequential controller that owns the single byte-wide port of the 2 KB instruction memory and shares it between the CPU fetch stage and the program loader. Fetches are word reads: the block issues four byte reads and assembles a big-endian 32-bit instruction. Loader writes are single bytes. Misaligned or out-of-range fetches are rejected with zero data and an error flag.

## Interface
- `DEPTH_BYTES`, default 2048: memory size in bytes; must be a power of two, at least 4.
- `ADDR_W`, default 11: memory byte-address width, equal to clog2(`DEPTH_BYTES`).

- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `fetch_req_i`, in, 1: fetch request; held until accepted.
- `fetch_addr_i`, in, 32: fetch byte address.
- `fetch_ready_o`, out, 1: fetch accepted this cycle when both this and `fetch_req_i` are high (combinational).
- `fetch_valid_o`, out, 1: one-cycle response pulse.
- `fetch_instr_o`, out, 32: assembled instruction; valid with `fetch_valid_o`.
- `fetch_err_o`, out, 1: fetch was misaligned or out of range; valid with `fetch_valid_o`.
- `load_req_i`, in, 1: loader byte-write request; held until `load_ack_o`.
- `load_addr_i`, in, `ADDR_W`: loader byte address.
- `load_data_i`, in, 8: loader byte.
- `load_ack_o`, out, 1: one-cycle pulse when the write is performed.
- `mem_addr_o`, out, `ADDR_W`: memory byte address (registered).
- `mem_we_o`, out, 1: memory write enable (registered).
- `mem_wdata_o`, out, 8: memory write data (registered).
- `mem_rdata_i`, in, 8: memory read data; synchronous, one-cycle latency after `mem_addr_o`.

## Operation
- **States:**
  - `IDLE`
  - `WRITE` (1 cycle)
  - `READ` (4 cycles, byte counter `cnt` 0..3)
  - `DRAIN` (1 cycle)
  - `RESP` (1 cycle)
- **Arbitration:** performed in `IDLE` only; no preemption.
  - If only one requester is active, it is granted.
  - If both are active, the requester *not* granted last is granted (round-robin bit `last_grant`).
  - Reset value of `last_grant` is LOAD, so fetch wins the first tie.
- `fetch_ready_o` = (state==`IDLE`) & (!`load_req_i` | `last_grant`==LOAD).
- **Load grant:** `IDLE`→`WRITE`. In `WRITE`:
  - `mem_we_o`=1, `mem_addr_o`=`load_addr_i`, `mem_wdata_o`=`load_data_i` (all captured at grant).
  - `load_ack_o`=1.
  - Next state `IDLE`; `last_grant`=LOAD.
- **Fetch grant, legal address** (`fetch_addr_i[1:0]`==0 and `fetch_addr_i` ≤ `DEPTH_BYTES`−4, evaluated on the full 32-bit value):
  - Base address is captured at grant; `IDLE`→`READ`.
  - `READ` with `cnt`=k drives `mem_addr_o`=base+k, k = 0..3.
  - Each returned byte is captured one cycle later: byte k lands in instr[31−8k : 24−8k] (big-endian).
  - After `cnt`=3, go to `DRAIN` (captures byte 3), then `RESP`.
  - `last_grant`=FETCH.
- **Fetch grant, illegal address:** `IDLE`→`RESP` directly. No memory access. Response is `fetch_err_o`=1, `fetch_instr_o`=0.
- **`RESP`:**
  - `fetch_valid_o`=1; `fetch_instr_o` and `fetch_err_o` are driven.
  - Next state `IDLE`.
  - `fetch_instr_o`/`fetch_err_o` hold their values until the next response.
- `mem_we_o`=0 in every state except `WRITE`. `mem_addr_o` and `mem_wdata_o` hold their last value when unused.
- Requesters dropping `fetch_req_i` or `load_req_i` after acceptance has no effect; the transaction completes.

## Timing
- **Reset (async, `rst_ni`=0):**
  - State `IDLE`, `cnt`=0, `last_grant`=LOAD.
  - Outputs: `fetch_valid_o`=0, `fetch_err_o`=0, `fetch_instr_o`=0, `load_ack_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
  - Reset mid-transaction aborts it silently; no response or ack is produced.
- **Legal fetch accepted in cycle T:**
  - `mem_addr_o`=base at T+1, base+1 at T+2, base+2 at T+3, base+3 at T+4.
  - Bytes arrive at T+2..T+5.
  - `fetch_valid_o` high at T+6.
  - `IDLE` again at T+7; the earliest next grant is at T+7.
- **Illegal fetch accepted at T:** `fetch_valid_o`=1, `fetch_err_o`=1 at T+1; `IDLE` at T+2.
- **Load accepted at T:** `mem_we_o`=1 and `load_ack_o`=1 at T+1; `IDLE` at T+2.
- **Ack semantics:** `load_ack_o` is registered, so the loader sees the ack one cycle after grant and must present its next byte no earlier than T+2.
- **Continuous contention:** grants alternate fetch, load, fetch, …

## Test plan
- **Preload and fetch:** memory[0x10..0x13] = 0xDE, 0xAD, 0xBE, 0xEF; fetch 0x10 accepted at T.
  - Expect `fetch_instr_o`=0xDEADBEEF with `fetch_valid_o`=1 exactly at T+6 and `fetch_err_o`=0.
  - Expect `mem_addr_o` sequence 0x10, 0x11, 0x12, 0x13 at T+1..T+4.
- **Misaligned and out-of-range fetches:**
  - Fetch 0x00000002 → at T+1, `fetch_valid_o`=1, `fetch_err_o`=1, `fetch_instr_o`=0; no change on `mem_addr_o`.
  - Repeat with 0x000007FD and 0x00000800 (both rejected).
  - Fetch 0x000007FC succeeds.
- **Loader writes:** write bytes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, waiting for each `load_ack_o`, then fetch 0x20.
  - Each ack is one cycle after its grant, with `mem_we_o`=1 and the matching address/data in that cycle.
  - The fetch returns 0x11223344.
- **Simultaneous requests from reset:** `fetch_req_i` and `load_req_i` both held high.
  - Fetch is granted first, then load, then fetch.
  - `fetch_ready_o`=0 on the cycles the load wins.
  - A load is never stalled more than one fetch transaction.
- **Request withdrawal:** `fetch_req_i` dropped at T+1 after acceptance at T → response still at T+6 with correct data.
- **Reset mid-read:** assert `rst_ni`=0 at T+3 of a fetch.
  - All outputs go to reset values immediately; no `fetch_valid_o` follows.
  - After release, a new fetch completes normally.
